// File: rtl/titan_bus_arbiter_pkg.sv
// Shared definitions for the titan_core two-master Wishbone arbiter:
// FSM encodings, one-hot grant constants and the default watchdog limit.
package titan_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } bus_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/titan_bus_timeout.sv
// Bus-cycle watchdog: counts waiting strobe cycles and flags expiry once the
// count reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it.
module titan_bus_timeout
  import titan_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Saturates at LIMIT so a held expiry never wraps back to a small count.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

endmodule

// File: rtl/titan_bus_arbiter.sv
// Merges titan_core's instruction and data Wishbone B4 classic ports onto one
// slave bus, with a locked grant per bus cycle and a stall watchdog.
module titan_bus_arbiter
  import titan_bus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN    = 0,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iwbs_addr_i,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  output logic [31:0] iwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic        dwbs_we_i,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  output logic [31:0] dwbs_dat_o,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic [1:0]  grant_o
);

  bus_state_e state, state_nxt;
  logic       last_d, last_d_nxt;
  logic       i_req, d_req;
  logic       own_cyc, own_stb;
  logic       wd_en, wd_clr, wd_expired, wd_fire;

  assign i_req = iwbs_cyc_i & iwbs_stb_i;
  assign d_req = dwbs_cyc_i & dwbs_stb_i;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    case (state)
      GNT_I: begin
        own_cyc = iwbs_cyc_i;
        own_stb = iwbs_stb_i;
      end
      GNT_D: begin
        own_cyc = dwbs_cyc_i;
        own_stb = dwbs_stb_i;
      end
      default: ;
    endcase
  end

  assign wd_en   = own_cyc & own_stb & ~wbm_ack_i & ~wbm_err_i;
  assign wd_clr  = ~wd_en;
  // A slave response in the expiry cycle wins over the abort.
  assign wd_fire = wd_expired & ~wbm_ack_i & ~wbm_err_i;

  titan_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en     (wd_en),
    .clr    (wd_clr),
    .expired(wd_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          state_nxt = ((ROUND_ROBIN != 0) && last_d) ? GNT_I : GNT_D;
        end else if (d_req) begin
          state_nxt = GNT_D;
        end else if (i_req) begin
          state_nxt = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (!own_cyc || wd_fire) begin
          state_nxt  = IDLE;
          last_d_nxt = (state == GNT_D);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction side is fetch-only: no write data, full-word selects.
  always_comb begin
    iwbs_dat_o = wbm_dat_i;
    dwbs_dat_o = wbm_dat_i;
    iwbs_ack_o = 1'b0;
    iwbs_err_o = 1'b0;
    dwbs_ack_o = 1'b0;
    dwbs_err_o = 1'b0;
    wbm_addr_o = '0;
    wbm_dat_o  = '0;
    wbm_sel_o  = '0;
    wbm_we_o   = 1'b0;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    grant_o    = GRANT_NONE;
    case (state)
      GNT_I: begin
        grant_o    = GRANT_I;
        wbm_addr_o = iwbs_addr_i;
        wbm_sel_o  = 4'hF;
        wbm_cyc_o  = iwbs_cyc_i & ~wd_expired;
        wbm_stb_o  = iwbs_stb_i & ~wd_expired;
        iwbs_ack_o = wbm_ack_i;
        iwbs_err_o = wbm_err_i | wd_fire;
      end
      GNT_D: begin
        grant_o    = GRANT_D;
        wbm_addr_o = dwbs_addr_i;
        wbm_dat_o  = dwbs_dat_i;
        wbm_sel_o  = dwbs_sel_i;
        wbm_we_o   = dwbs_we_i;
        wbm_cyc_o  = dwbs_cyc_i & ~wd_expired;
        wbm_stb_o  = dwbs_stb_i & ~wd_expired;
        dwbs_ack_o = wbm_ack_i;
        dwbs_err_o = wbm_err_i | wd_fire;
      end
      default: ;
    endcase
  end

endmodule
